// File: rtl/uart_dbg_master.sv
// UART-to-register-bus debug bridge: decodes W/R host frames from the RX byte
// stream, runs one register bus transaction and answers through the TX byte port.
module uart_dbg_master #(
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] CMD_WR         = 8'h57,
    parameter logic [7:0] CMD_RD         = 8'h52
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rvld,
    input  logic [7:0]  rdata,
    output logic        tvld,
    output logic [7:0]  tdata,
    input  logic        trdy,
    input  logic        bus_gnt,
    output logic        bus_req,
    output logic        reg_bus_we,
    output logic        reg_bus_rd,
    output logic [31:0] reg_bus_addr,
    output logic [31:0] reg_bus_wdat,
    input  logic [31:0] reg_bus_rdat,
    output logic        rx_drop,
    output logic        timeout
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP, ERR} state_t;

    state_t        state, state_nx;
    logic          is_wr;
    logic [1:0]    byte_cnt;
    logic [1:0]    tx_cnt;
    logic [31:0]   resp_buf;
    logic [TW-1:0] to_cnt;
    logic          in_frame, expire, last_tx, tx_done;

    assign in_frame = (state == ADDR) || (state == DATA);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign expire   = in_frame && !rvld && (to_cnt == TW'(TIMEOUT_CYCLES));
    assign last_tx  = (state == ERR) || is_wr || (tx_cnt == 2'd3);
    assign tx_done  = tvld && trdy && last_tx;

    assign bus_req    = (state == BUS);
    assign reg_bus_we = bus_req && bus_gnt && is_wr;
    assign reg_bus_rd = bus_req && bus_gnt && !is_wr;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (rvld) state_nx = (rdata == CMD_WR || rdata == CMD_RD) ? ADDR : ERR;
            ADDR: begin
                if (rvld && byte_cnt == 2'd3) state_nx = is_wr ? DATA : BUS;
                else if (expire)              state_nx = IDLE;
            end
            DATA: begin
                if (rvld && byte_cnt == 2'd3) state_nx = BUS;
                else if (expire)              state_nx = IDLE;
            end
            BUS:  if (bus_gnt) state_nx = RESP;
            RESP: if (tx_done) state_nx = IDLE;
            ERR:  if (tx_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_wr        <= 1'b0;
            byte_cnt     <= 2'd0;
            tx_cnt       <= 2'd0;
            resp_buf     <= 32'h0;
            to_cnt       <= '0;
            tvld         <= 1'b0;
            tdata        <= 8'h0;
            reg_bus_addr <= 32'h0;
            reg_bus_wdat <= 32'h0;
            rx_drop      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            rx_drop <= rvld && (state == BUS || state == RESP || state == ERR);
            timeout <= expire;

            if (in_frame && !rvld && !expire) to_cnt <= to_cnt + TW'(1);
            else                              to_cnt <= '0;

            case (state)
                IDLE: if (rvld) begin
                    is_wr    <= (rdata == CMD_WR);
                    byte_cnt <= 2'd0;
                end
                ADDR: if (rvld) begin
                    reg_bus_addr <= {reg_bus_addr[23:0], rdata};
                    byte_cnt     <= byte_cnt + 2'd1;
                end
                DATA: if (rvld) begin
                    reg_bus_wdat <= {reg_bus_wdat[23:0], rdata};
                    byte_cnt     <= byte_cnt + 2'd1;
                end
                BUS: begin
                    tx_cnt <= 2'd0;
                    if (reg_bus_rd) resp_buf <= reg_bus_rdat;
                end
                RESP, ERR: begin
                    // Read data leaves MSB first; the buffer shifts up as bytes go out.
                    if (!tvld) begin
                        tvld  <= 1'b1;
                        tdata <= (state == ERR) ? 8'h45 : (is_wr ? 8'h4B : resp_buf[31:24]);
                    end else if (trdy) begin
                        tx_cnt <= tx_cnt + 2'd1;
                        if (last_tx) begin
                            tvld <= 1'b0;
                        end else begin
                            tdata    <= resp_buf[23:16];
                            resp_buf <= {resp_buf[23:0], 8'h0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_dbg_master.sv
// Bench for uart_dbg_master: frame-level scoreboard of expected bus transactions
// and response bytes, checked every cycle, plus literal checks from hand-worked frames.
module tb_uart_dbg_master;
    localparam int T = 100;

    logic        clk = 0, rst = 1, rvld = 0, trdy = 1, bus_gnt = 1;
    logic [7:0]  rdata = 0;
    logic [31:0] reg_bus_rdat = 0;
    logic        tvld, bus_req, reg_bus_we, reg_bus_rd, rx_drop, timeout;
    logic [7:0]  tdata;
    logic [31:0] reg_bus_addr, reg_bus_wdat;

    uart_dbg_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .rvld(rvld), .rdata(rdata), .tvld(tvld), .tdata(tdata),
        .trdy(trdy), .bus_gnt(bus_gnt), .bus_req(bus_req), .reg_bus_we(reg_bus_we),
        .reg_bus_rd(reg_bus_rd), .reg_bus_addr(reg_bus_addr), .reg_bus_wdat(reg_bus_wdat),
        .reg_bus_rdat(reg_bus_rdat), .rx_drop(rx_drop), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdat;
    } bus_t;

    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_log[$];
    int          n_chk = 0, n_err = 0;
    int          drop_cnt = 0, to_cnt = 0, we_cnt = 0, rd_cnt = 0, trdy_mode = 0;
    logic [31:0] last_wdat = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rvld = 1; rdata = b;
        tick();
        rvld = 0;
        repeat (gap) tick();
    endtask

    // kind: 0 bad command, 1 write, 2 read. Last byte always has no trailing gap.
    task automatic frame(input int kind, input logic [31:0] a, input logic [31:0] d,
                         input int gap, input logic [7:0] badb);
        bus_t       e;
        logic [7:0] bs[$];
        if (kind == 0) begin
            exp_tx.push_back(8'h45);
            send_byte(badb, 0);
            return;
        end
        e.we   = (kind == 1);
        e.addr = a;
        e.wdat = (kind == 1) ? d : last_wdat;
        exp_bus.push_back(e);
        bs.push_back(kind == 1 ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) bs.push_back(a[8*i +: 8]);
        if (kind == 1) begin
            last_wdat = d;
            exp_tx.push_back(8'h4B);
            for (int i = 3; i >= 0; i--) bs.push_back(d[8*i +: 8]);
        end else begin
            for (int i = 3; i >= 0; i--) exp_tx.push_back(reg_bus_rdat[8*i +: 8]);
        end
        for (int i = 0; i < bs.size(); i++) send_byte(bs[i], (i == bs.size() - 1) ? 0 : gap);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0 || tvld) && n < 3000) begin
            tick();
            n++;
        end
        chk({nm, "_done"}, 32'(n < 3000), 32'd1);
    endtask

    // Transmitter ready: 0 always, 1 random, 2 twenty cycles low per byte, 3 never.
    int hcnt = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (trdy_mode)
            0: trdy = 1;
            1: trdy = 1'($urandom % 2);
            2: begin
                if (!tvld || trdy) begin hcnt = 0; trdy = 0; end
                else begin hcnt++; trdy = (hcnt >= 20); end
            end
            default: trdy = 0;
        endcase
    end

    bus_t       ce;
    logic       p_hold = 0;
    logic [7:0] p_data = 0;
    always @(negedge clk) begin
        if (rst) begin
            p_hold = 0;
        end else begin
            if (p_hold) chk("tdata_hold", {23'h0, tvld, tdata}, {23'h0, 1'b1, p_data});
            if (reg_bus_we || reg_bus_rd) begin
                if (reg_bus_we) we_cnt++;
                if (reg_bus_rd) rd_cnt++;
                chk("strobe_req_gnt", {reg_bus_we & reg_bus_rd, bus_req, bus_gnt}, 3'b011);
                if (exp_bus.size() == 0) begin
                    chk("unexpected_strobe", {reg_bus_we, reg_bus_rd}, 2'b00);
                end else begin
                    ce = exp_bus.pop_front();
                    chk("strobe_kind", {reg_bus_we, reg_bus_rd}, {ce.we, !ce.we});
                    chk("bus_addr", reg_bus_addr, ce.addr);
                    chk("bus_wdat", reg_bus_wdat, ce.wdat);
                end
            end
            if (tvld && trdy) begin
                tx_log.push_back(tdata);
                if (exp_tx.size() == 0) chk("unexpected_tx", {23'h0, tvld, tdata}, 32'h0);
                else chk("tx_byte", tdata, exp_tx.pop_front());
            end
            if (rx_drop) drop_cnt++;
            if (timeout) to_cnt++;
            p_hold = tvld && !trdy;
            p_data = tdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, w0, t0, n, kind, dly, exp_drop;
        logic [31:0] a, d;
        logic [7:0]  b;

        repeat (3) tick();
        chk("rst_tx", {tvld, tdata}, 0);
        chk("rst_bus", {bus_req, reg_bus_we, reg_bus_rd, rx_drop, timeout}, 0);
        chk("rst_addr", reg_bus_addr, 0);
        chk("rst_wdat", reg_bus_wdat, 0);
        rst = 0;
        tick();

        // Write frame from the plan.
        tx_log.delete();
        frame(1, 32'h80000104, 32'h12345678, 0, 8'h0);
        chk("wr_latency", reg_bus_we, 1);
        wait_idle("wr");
        chk("wr_addr_lit", reg_bus_addr, 32'h80000104);
        chk("wr_wdat_lit", reg_bus_wdat, 32'h12345678);
        chk("wr_resp_len", tx_log.size(), 1);
        chk("wr_resp_lit", tx_log[0], 8'h4B);

        // Read frame from the plan; wdat keeps the previous value.
        tx_log.delete();
        r0 = rd_cnt;
        reg_bus_rdat = 32'hDEADBEEF;
        frame(2, 32'h80000200, 0, 1, 8'h0);
        wait_idle("rd");
        chk("rd_pulses", rd_cnt - r0, 1);
        chk("rd_resp_len", tx_log.size(), 4);
        chk("rd_resp_lit", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'hDEADBEEF);
        chk("rd_wdat_kept", reg_bus_wdat, 32'h12345678);

        // Grant stall with an extra byte dropped during the wait.
        d0 = drop_cnt; r0 = rd_cnt;
        bus_gnt = 0;
        reg_bus_rdat = $urandom;
        frame(2, $urandom, 0, 0, 8'h0);
        send_byte(8'hAA, 0);
        repeat (50) begin
            chk("stall_req", bus_req, 1);
            chk("stall_nostrobe", {reg_bus_we, reg_bus_rd}, 0);
            tick();
        end
        bus_gnt = 1;
        wait_idle("stall");
        chk("stall_drop", drop_cnt - d0, 1);
        chk("stall_rd_pulses", rd_cnt - r0, 1);

        // Bad command, then a normal frame.
        tx_log.delete();
        r0 = rd_cnt; w0 = we_cnt;
        frame(0, 0, 0, 0, 8'h41);
        wait_idle("bad");
        chk("bad_resp_lit", {tx_log.size() == 1, tx_log[0]}, {1'b1, 8'h45});
        chk("bad_no_bus", (rd_cnt - r0) + (we_cnt - w0), 0);
        frame(1, $urandom, $urandom, 0, 8'h0);
        wait_idle("after_bad");

        // Inter-byte timeout: silence after a partial frame.
        t0 = to_cnt;
        send_byte(8'h57, 0); send_byte(8'h80, 0); send_byte(8'h00, 0);
        repeat (T + 10) tick();
        chk("timeout_pulse", to_cnt - t0, 1);
        chk("timeout_no_tx", tvld, 0);
        reg_bus_rdat = $urandom;
        frame(2, $urandom, 0, 0, 8'h0);
        wait_idle("after_timeout");

        // Byte arriving exactly at expiry keeps the frame alive.
        t0 = to_cnt;
        frame(1, $urandom, $urandom, T, 8'h0);
        wait_idle("edge_gap");
        chk("edge_gap_no_timeout", to_cnt - t0, 0);

        // Backpressure: transmitter stalls each byte.
        trdy_mode = 2;
        reg_bus_rdat = $urandom;
        frame(2, $urandom, 0, 0, 8'h0);
        wait_idle("backpressure");

        // Reset in the middle of a response.
        trdy_mode = 3;
        reg_bus_rdat = $urandom;
        frame(2, $urandom, 0, 0, 8'h0);
        n = 0;
        while (!tvld && n < 100) begin tick(); n++; end
        chk("resp_started", tvld, 1);
        repeat (3) tick();
        rst = 1;
        tick();
        rst = 0;
        chk("midrst_tx", {tvld, tdata}, 0);
        chk("midrst_bus", {bus_req, reg_bus_we, reg_bus_rd, rx_drop, timeout}, 0);
        chk("midrst_regs", reg_bus_addr | reg_bus_wdat, 0);
        exp_tx.delete();
        last_wdat = 0;
        trdy_mode = 0;
        reg_bus_rdat = $urandom;
        frame(2, $urandom, 0, 0, 8'h0);
        wait_idle("after_rst");

        // Randomised frames.
        d0 = drop_cnt; t0 = to_cnt;
        exp_drop = 0;
        for (int i = 0; i < 40; i++) begin
            trdy_mode = $urandom % 2;
            kind = $urandom % 8;
            kind = (kind == 0) ? 0 : (kind < 4) ? 1 : 2;
            dly = (kind == 0) ? 0 : int'($urandom % 6);
            a = $urandom; d = $urandom;
            reg_bus_rdat = $urandom;
            do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
            bus_gnt = (dly == 0);
            frame(kind, a, d, int'($urandom % 4), b);
            if (dly > 0) begin
                if ($urandom % 2 == 1) begin
                    send_byte(8'($urandom), 0);
                    exp_drop++;
                end
                repeat (dly) tick();
                bus_gnt = 1;
            end
            wait_idle("rand");
        end
        trdy_mode = 0;
        tick();
        chk("rand_drops", drop_cnt - d0, exp_drop);
        chk("rand_no_timeout", to_cnt - t0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
